ysyx_24120013_mc_ctrl: RTL and testbench
========================================

# ysyx_24120013_mc_ctrl

Multi-cycle sequencer that replaces the free-running single-cycle PC/fetch path of the NPC top with a parametrised fetch–decode–execute–memory–writeback state machine. It owns the PC. It drives valid/ready handshakes toward instruction and data memory, gates register-file writes to one pulse per instruction, and counts retired instructions. IDU, EXU and RegisterFile attach to it. It stops the core on ebreak, illegal instruction or bus timeout.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction/data width
- RESET_PC, 32'h8000_0000, PC value after reset
- TIMEOUT, 255, max wait cycles in any bus-wait state before error halt
- CNT_WIDTH, 32, retire counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  out  1  fetch request valid
- if_addr  out  ADDR_WIDTH  fetch address (= pc)
- if_ready  in  1  fetch request accepted when if_req&if_ready
- if_rvalid  in  1  fetch data valid
- if_rdata  in  DATA_WIDTH  fetched instruction
- inst  out  DATA_WIDTH  latched instruction to IDU
- dec_load, dec_store, dec_ebreak, dec_illegal  in  1 each  IDU decode flags
- dec_wb  in  1  instruction writes rd
- exu_jmp_en  in  1  taken branch/jump
- exu_next_pc  in  ADDR_WIDTH  branch/jump target
- lsu_req  out  1  data request valid
- lsu_ready  in  1  data request accepted
- lsu_rvalid  in  1  load data / store ack valid
- rf_wen  out  1  register-file write strobe
- pc  out  ADDR_WIDTH  current PC
- retire  out  1  one-cycle pulse per retired instruction
- retire_cnt  out  CNT_WIDTH  retired instruction count
- halted  out  1  core stopped
- err  out  1  stop caused by illegal instruction or timeout

## Operation
- States: FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT.
- FETCH:
  - if_req=1, held until if_ready.
  - On accept, clear timeout counter and go to FWAIT.
  - if_addr must stay stable while if_req is high.
- FWAIT:
  - On if_rvalid, latch if_rdata into inst and go to DECODE.
  - if_rvalid is ignored outside FWAIT.
- DECODE: sample dec_* flags into registers.
  - dec_illegal: go to HALT with err=1.
  - dec_ebreak: go to HALT with err=0.
  - Otherwise go to EXEC.
- EXEC: register exu_jmp_en and exu_next_pc.
  - If load or store, go to MEM; otherwise go to WB.
- MEM: lsu_req=1 until lsu_ready, then go to MWAIT.
- MWAIT: on lsu_rvalid, go to WB.
- WB:
  - rf_wen=dec_wb (registered value) for exactly this cycle; store forces rf_wen=0.
  - retire=1.
  - retire_cnt += 1, wrapping modulo 2^CNT_WIDTH.
  - pc <= jmp ? next_pc : pc+4, modulo 2^ADDR_WIDTH.
  - Go to FETCH.
- Timeout:
  - A counter increments each cycle spent in FETCH (not accepted), FWAIT, MEM (not accepted) or MWAIT.
  - It resets on every state change.
  - When it reaches TIMEOUT: go to HALT with err=1, pc unchanged, no retire.
- HALT:
  - Absorbing; halted=1.
  - All request strobes, rf_wen and retire are 0.
  - Left only by reset.
- Reset (async, mid-operation included):
  - State FETCH, pc=RESET_PC, inst=0.
  - retire_cnt, halted, err, timeout counter and all strobes = 0.
  - Outstanding bus transactions are abandoned.
  - First if_req is asserted in the first clk edge cycle after rst deasserts.

## Timing
- All outputs registered or decoded from the state register only; no input-to-output combinational path.
- Zero-wait bus (ready=1, rvalid the cycle after accept):
  - ALU instruction: 5 cycles (FETCH, FWAIT, DECODE, EXEC, WB).
  - Load/store: 7 cycles.
- Same-cycle ready-and-rvalid in FETCH does not complete the fetch; rvalid is only sampled in FWAIT.
- Timeout boundary: wait cycle number TIMEOUT transitions to HALT on the next edge. A response arriving in that same cycle takes priority and completes normally.
- pc changes only on the WB→FETCH edge.
- retire_cnt updates on the same edge.

## Test plan
- Reset and zero-wait fetches:
  - Stimulus: reset, then 3 ALU instructions, all dec_wb=1.
  - Required: pc sequence 0x80000000, 0x80000004, 0x80000008; retire pulses 5 cycles apart; retire_cnt=3; rf_wen high exactly 3 cycles.
- Taken jump:
  - Stimulus: exu_jmp_en=1, exu_next_pc=0x80000100.
  - Required: next if_addr=0x80000100; retire_cnt increments once.
- Load with 4-cycle lsu_ready stall and 2-cycle rvalid delay:
  - Required: lsu_req held stable 5 cycles; instruction completes in 7+6 cycles; single rf_wen.
- Store:
  - Required: rf_wen=0; retire=1.
- Timeout:
  - Stimulus: TIMEOUT=8, if_rvalid never asserted.
  - Required: halted=1 and err=1 after 8 FWAIT cycles; if_req stays 0 afterward; retire_cnt unchanged.
- ebreak after 2 instructions:
  - Required: halted=1, err=0, retire_cnt=2.
- Reset mid-MWAIT:
  - Required: outputs return immediately (asynchronously) to reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_24120013_mc_ctrl_if.sv
// Fetch and load/store handshake bundle between the multi-cycle sequencer and memory.
// The master side issues requests; the slave side answers with ready/rvalid/rdata.
interface ysyx_24120013_mc_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  lsu_req;
  logic                  lsu_ready;
  logic                  lsu_rvalid;

  modport master (
    output if_req, if_addr, lsu_req,
    input  if_ready, if_rvalid, if_rdata, lsu_ready, lsu_rvalid
  );

  modport slave (
    input  if_req, if_addr, lsu_req,
    output if_ready, if_rvalid, if_rdata, lsu_ready, lsu_rvalid
  );
endinterface

// File: rtl/ysyx_24120013_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the PC, drives the bus
// handshakes, gates register writes to one pulse per instruction and halts on error.
module ysyx_24120013_mc_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned           TIMEOUT    = 255,
  parameter int unsigned           CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_24120013_mc_ctrl_if.master bus,
  output logic [DATA_WIDTH-1:0]  inst,
  input  logic                   dec_load,
  input  logic                   dec_store,
  input  logic                   dec_ebreak,
  input  logic                   dec_illegal,
  input  logic                   dec_wb,
  input  logic                   exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0]  exu_next_pc,
  output logic                   rf_wen,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   retire,
  output logic [CNT_WIDTH-1:0]   retire_cnt,
  output logic                   halted,
  output logic                   err
);
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] next_pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [CNT_WIDTH-1:0]  retire_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  if_req_q, lsu_req_q, rf_wen_q, retire_q, halted_q, err_q;
  logic                  load_q, store_q, wb_q, jmp_q;
  logic                  tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // All strobes are registered alongside the state transition that enables them.
  // After reset the first FETCH cycle only raises if_req, so nothing is requested while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc_q         <= RESET_PC;
      next_pc_q    <= '0;
      inst_q       <= '0;
      retire_cnt_q <= '0;
      tmo_cnt      <= '0;
      if_req_q     <= 1'b0;
      lsu_req_q    <= 1'b0;
      rf_wen_q     <= 1'b0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      wb_q         <= 1'b0;
      jmp_q        <= 1'b0;
    end else begin
      rf_wen_q <= 1'b0;
      retire_q <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!if_req_q) begin
            if_req_q <= 1'b1;
          end else if (bus.if_ready) begin
            if_req_q <= 1'b0;
            tmo_cnt  <= '0;
            state    <= S_FWAIT;
          end else if (tmo_hit) begin
            if_req_q <= 1'b0;
            halted_q <= 1'b1;
            err_q    <= 1'b1;
            state    <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_FWAIT: begin
          // A response in the last allowed wait cycle wins over the timeout.
          if (bus.if_rvalid) begin
            inst_q  <= bus.if_rdata;
            tmo_cnt <= '0;
            state   <= S_DECODE;
          end else if (tmo_hit) begin
            halted_q <= 1'b1;
            err_q    <= 1'b1;
            state    <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DECODE: begin
          load_q  <= dec_load;
          store_q <= dec_store;
          wb_q    <= dec_wb;
          if (dec_illegal) begin
            halted_q <= 1'b1;
            err_q    <= 1'b1;
            state    <= S_HALT;
          end else if (dec_ebreak) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          jmp_q     <= exu_jmp_en;
          next_pc_q <= exu_next_pc;
          if (load_q || store_q) begin
            lsu_req_q <= 1'b1;
            state     <= S_MEM;
          end else begin
            rf_wen_q <= wb_q;
            retire_q <= 1'b1;
            state    <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.lsu_ready) begin
            lsu_req_q <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_MWAIT;
          end else if (tmo_hit) begin
            lsu_req_q <= 1'b0;
            halted_q  <= 1'b1;
            err_q     <= 1'b1;
            state     <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_MWAIT: begin
          if (bus.lsu_rvalid) begin
            rf_wen_q <= wb_q & ~store_q;
            retire_q <= 1'b1;
            tmo_cnt  <= '0;
            state    <= S_WB;
          end else if (tmo_hit) begin
            halted_q <= 1'b1;
            err_q    <= 1'b1;
            state    <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_WB: begin
          pc_q         <= jmp_q ? next_pc_q : pc_q + ADDR_WIDTH'(4);
          retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(1);
          if_req_q     <= 1'b1;
          state        <= S_FETCH;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign bus.if_req  = if_req_q;
  assign bus.if_addr = pc_q;
  assign bus.lsu_req = lsu_req_q;
  assign inst        = inst_q;
  assign rf_wen      = rf_wen_q;
  assign pc          = pc_q;
  assign retire      = retire_q;
  assign retire_cnt  = retire_cnt_q;
  assign halted      = halted_q;
  assign err         = err_q;
endmodule

// File: tb/tb_ysyx_24120013_mc_ctrl.sv
// Directed bench for the multi-cycle sequencer: a reactive memory responder plus
// one task per scenario with hand-computed expectations.
module tb_ysyx_24120013_mc_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam logic [AW-1:0] RPC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] inst;
  logic          dec_load = 1'b0, dec_store = 1'b0, dec_ebreak = 1'b0;
  logic          dec_illegal = 1'b0, dec_wb = 1'b0;
  logic          exu_jmp_en = 1'b0;
  logic [AW-1:0] exu_next_pc = '0;
  logic          rf_wen, retire, halted, err;
  logic [AW-1:0] pc;
  logic [CW-1:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rf_seen = 0;
  int lsu_seen = 0;

  bit f_never = 1'b0;
  int f_lat = 0, l_stall = 0, l_lat = 0;

  ysyx_24120013_mc_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_24120013_mc_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC), .TIMEOUT(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst),
    .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak),
    .dec_illegal(dec_illegal), .dec_wb(dec_wb),
    .exu_jmp_en(exu_jmp_en), .exu_next_pc(exu_next_pc),
    .rf_wen(rf_wen), .pc(pc), .retire(retire), .retire_cnt(retire_cnt),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rf_wen === 1'b1) rf_seen++;
    if (bus.lsu_req === 1'b1) lsu_seen++;
  end

  // Memory responder: fetch always accepted, data returned f_lat cycles into FWAIT;
  // lsu accepted after l_stall cycles, response l_lat cycles into MWAIT.
  initial begin
    bit fpend, lpend;
    int fcnt, lcnt, scnt;
    logic [AW-1:0] faddr;
    fpend = 0; lpend = 0; fcnt = 0; lcnt = 0; scnt = 0; faddr = '0;
    bus.if_ready = 0; bus.if_rvalid = 0; bus.if_rdata = '0;
    bus.lsu_ready = 0; bus.lsu_rvalid = 0;
    forever begin
      @(negedge clk);
      bus.if_rvalid = 0;
      bus.lsu_rvalid = 0;
      bus.lsu_ready = 0;
      if (!rst_n) begin
        fpend = 0; lpend = 0; scnt = 0;
        bus.if_ready = 0;
      end else begin
        if (fpend) begin
          if (!f_never && fcnt == f_lat) begin
            bus.if_rvalid = 1;
            bus.if_rdata  = faddr + 32'h1234;
            fpend = 0;
          end else begin
            fcnt++;
          end
        end
        bus.if_ready = 1;
        if (bus.if_req === 1'b1) begin
          fpend = 1; fcnt = 0; faddr = bus.if_addr;
        end
        if (lpend) begin
          if (lcnt == l_lat) begin
            bus.lsu_rvalid = 1;
            lpend = 0;
          end else begin
            lcnt++;
          end
        end
        if (bus.lsu_req === 1'b1) begin
          if (scnt == l_stall) begin
            bus.lsu_ready = 1; lpend = 1; lcnt = 0; scnt = 0;
          end else begin
            scnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset;
    dec_load = 0; dec_store = 0; dec_ebreak = 0; dec_illegal = 0; dec_wb = 0;
    exu_jmp_en = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_retire(output bit ok, output int at);
    ok = 0; at = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (retire === 1'b1) begin ok = 1; at = cyc; end
    end
  endtask

  task automatic wait_halt(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (halted === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (bus.if_req !== 1'b0) begin errors++; $display("FAIL rst_if_req: got %b want 0", bus.if_req); end
    checks++; if (bus.lsu_req !== 1'b0) begin errors++; $display("FAIL rst_lsu_req: got %b want 0", bus.lsu_req); end
    checks++; if (pc !== RPC) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, RPC); end
    checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL rst_retire_cnt: got %0d want 0", retire_cnt); end
    checks++; if ({halted, err, rf_wen, retire} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {halted, err, rf_wen, retire}); end
    checks++; if (inst !== '0) begin errors++; $display("FAIL rst_inst: got %h want 0", inst); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (bus.if_req !== 1'b1) begin errors++; $display("FAIL first_if_req: got %b want 1", bus.if_req); end
    checks++; if (bus.if_addr !== RPC) begin errors++; $display("FAIL first_if_addr: got %h want %h", bus.if_addr, RPC); end
  endtask

  task automatic test_alu;
    bit ok;
    int at [3];
    int rf0;
    rf0 = rf_seen;
    dec_wb = 1;
    for (int i = 0; i < 3; i++) begin
      wait_retire(ok, at[i]);
      checks++; if (!ok) begin errors++; $display("FAIL alu_retire%0d: got none want pulse", i); end
      checks++; if (pc !== RPC + 32'(4 * i)) begin errors++; $display("FAIL alu_pc%0d: got %h want %h", i, pc, RPC + 32'(4 * i)); end
      checks++; if (inst !== RPC + 32'(4 * i) + 32'h1234) begin errors++; $display("FAIL alu_inst%0d: got %h want %h", i, inst, RPC + 32'(4 * i) + 32'h1234); end
      checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL alu_rf_wen%0d: got %b want 1", i, rf_wen); end
    end
    checks++; if (at[1] - at[0] != 5) begin errors++; $display("FAIL alu_gap01: got %0d want 5", at[1] - at[0]); end
    checks++; if (at[2] - at[1] != 5) begin errors++; $display("FAIL alu_gap12: got %0d want 5", at[2] - at[1]); end
    @(negedge clk);
    checks++; if (retire_cnt !== 32'd3) begin errors++; $display("FAIL alu_retire_cnt: got %0d want 3", retire_cnt); end
    checks++; if (bus.if_addr !== RPC + 32'd12) begin errors++; $display("FAIL alu_next_addr: got %h want %h", bus.if_addr, RPC + 32'd12); end
    checks++; if (rf_seen - rf0 != 3) begin errors++; $display("FAIL alu_rf_wen_cycles: got %0d want 3", rf_seen - rf0); end
  endtask

  task automatic test_jump;
    bit ok;
    int at;
    exu_jmp_en = 1;
    exu_next_pc = 32'h8000_0100;
    wait_retire(ok, at);
    checks++; if (!ok || pc !== 32'h8000_000C) begin errors++; $display("FAIL jmp_retire_pc: got ok=%b pc=%h want 1 8000000c", ok, pc); end
    exu_jmp_en = 0;
    @(negedge clk);
    checks++; if (bus.if_addr !== 32'h8000_0100) begin errors++; $display("FAIL jmp_target: got %h want 80000100", bus.if_addr); end
    checks++; if (retire_cnt !== 32'd4) begin errors++; $display("FAIL jmp_retire_cnt: got %0d want 4", retire_cnt); end
  endtask

  task automatic test_load;
    bit ok;
    int at, start, rf0, ls0;
    dec_load = 1; dec_wb = 1; l_stall = 4; l_lat = 2;
    rf0 = rf_seen; ls0 = lsu_seen; start = cyc;
    wait_retire(ok, at);
    checks++; if (!ok || at - start != 12) begin errors++; $display("FAIL load_latency: got ok=%b %0d want 12", ok, at - start); end
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL load_rf_wen: got %b want 1", rf_wen); end
    checks++; if (lsu_seen - ls0 != 5) begin errors++; $display("FAIL load_lsu_req_cycles: got %0d want 5", lsu_seen - ls0); end
    dec_load = 0; l_stall = 0; l_lat = 0;
    @(negedge clk);
    checks++; if (rf_seen - rf0 != 1) begin errors++; $display("FAIL load_single_rf_wen: got %0d want 1", rf_seen - rf0); end
    checks++; if (retire_cnt !== 32'd5 || bus.if_addr !== 32'h8000_0104) begin errors++; $display("FAIL load_after: got cnt=%0d addr=%h want 5 80000104", retire_cnt, bus.if_addr); end
  endtask

  task automatic test_store;
    bit ok;
    int at, start, rf0;
    dec_store = 1; dec_wb = 1;
    rf0 = rf_seen; start = cyc;
    wait_retire(ok, at);
    checks++; if (!ok || at - start != 6) begin errors++; $display("FAIL store_latency: got ok=%b %0d want 6", ok, at - start); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL store_rf_wen: got %b want 0", rf_wen); end
    dec_store = 0;
    @(negedge clk);
    checks++; if (rf_seen - rf0 != 0) begin errors++; $display("FAIL store_rf_wen_cycles: got %0d want 0", rf_seen - rf0); end
    checks++; if (retire_cnt !== 32'd6 || bus.if_addr !== 32'h8000_0108) begin errors++; $display("FAIL store_after: got cnt=%0d addr=%h want 6 80000108", retire_cnt, bus.if_addr); end
  endtask

  task automatic test_timeout;
    int req_hi;
    f_never = 1;
    apply_reset();
    repeat (8) @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL tmo_early: got halted=%b want 0", halted); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL tmo_halt: got halted=%b err=%b want 1 1", halted, err); end
    req_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.if_req !== 1'b0 || retire !== 1'b0) req_hi++;
    end
    checks++; if (req_hi != 0) begin errors++; $display("FAIL tmo_quiet: got %0d active cycles want 0", req_hi); end
    checks++; if (retire_cnt !== '0 || pc !== RPC) begin errors++; $display("FAIL tmo_state: got cnt=%0d pc=%h want 0 %h", retire_cnt, pc, RPC); end
    f_never = 0;
  endtask

  task automatic test_timeout_edge;
    bit ok;
    int at;
    f_lat = 7;
    apply_reset();
    dec_wb = 1;
    wait_retire(ok, at);
    checks++; if (!ok || halted !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL tmo_edge: got ok=%b halted=%b err=%b want 1 0 0", ok, halted, err); end
    f_lat = 0;
    @(negedge clk);
    checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL tmo_edge_cnt: got %0d want 1", retire_cnt); end
  endtask

  task automatic test_illegal;
    bit ok;
    apply_reset();
    dec_illegal = 1;
    wait_halt(ok);
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL illegal: got ok=%b err=%b want 1 1", ok, err); end
    checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL illegal_cnt: got %0d want 0", retire_cnt); end
    dec_illegal = 0;
  endtask

  task automatic test_ebreak;
    bit ok;
    int at, act;
    apply_reset();
    dec_wb = 1;
    wait_retire(ok, at);
    wait_retire(ok, at);
    dec_ebreak = 1;
    wait_halt(ok);
    checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL ebreak: got ok=%b err=%b want 1 0", ok, err); end
    checks++; if (retire_cnt !== 32'd2 || pc !== RPC + 32'd8) begin errors++; $display("FAIL ebreak_state: got cnt=%0d pc=%h want 2 %h", retire_cnt, pc, RPC + 32'd8); end
    act = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.if_req !== 1'b0 || retire !== 1'b0 || rf_wen !== 1'b0 || halted !== 1'b1) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL ebreak_absorb: got %0d bad cycles want 0", act); end
    dec_ebreak = 0;
  endtask

  task automatic test_reset_mwait;
    bit ok, seen;
    int at;
    apply_reset();
    dec_wb = 1;
    wait_retire(ok, at);
    dec_load = 1; l_stall = 0; l_lat = 5;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.lsu_req === 1'b1) seen = 1;
    end
    repeat (2) @(negedge clk);
    checks++; if (!seen || retire_cnt !== 32'd1 || pc !== RPC + 32'd4) begin errors++; $display("FAIL mwait_setup: got seen=%b cnt=%0d pc=%h want 1 1 %h", seen, retire_cnt, pc, RPC + 32'd4); end
    #2 rst_n = 0;
    #1;
    checks++; if (pc !== RPC || retire_cnt !== '0 || inst !== '0) begin errors++; $display("FAIL mwait_rst_regs: got pc=%h cnt=%0d inst=%h want %h 0 0", pc, retire_cnt, inst, RPC); end
    checks++; if ({bus.if_req, bus.lsu_req, rf_wen, retire, halted, err} !== 6'b0) begin errors++; $display("FAIL mwait_rst_strobes: got %b want 000000", {bus.if_req, bus.lsu_req, rf_wen, retire, halted, err}); end
    dec_load = 0; l_lat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_retire(ok, at);
    checks++; if (!ok || pc !== RPC) begin errors++; $display("FAIL mwait_restart: got ok=%b pc=%h want 1 %h", ok, pc, RPC); end
    @(negedge clk);
    checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL mwait_restart_cnt: got %0d want 1", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jump();
    test_load();
    test_store();
    test_timeout();
    test_timeout_edge();
    test_illegal();
    test_ebreak();
    test_reset_mwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
